// File: rtl/accumulator_par_if.sv
// accumulator_par_if: sample/result bundle for accumulator_par.
//   master : producer/consumer side; drives in_valid, in_data, result_ready
//   slave  : accumulator side; drives in_ready, result_valid, result,
//            overflow, beat_count
// Parameters must match those of the accumulator_par instance attached.
interface accumulator_par_if #(
   parameter int DATA_W      = 16,
   parameter int LANES       = 4,
   parameter int SUM_W       = 32,
   parameter int BLOCK_BEATS = 256
);
   localparam int BC_W = $clog2(BLOCK_BEATS + 1);

   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_data;
   logic                    result_valid;
   logic                    result_ready;
   logic [SUM_W-1:0]        result;
   logic                    overflow;
   logic [BC_W-1:0]         beat_count;

   modport master (
      output in_valid, in_data, result_ready,
      input  in_ready, result_valid, result, overflow, beat_count
   );

   modport slave (
      input  in_valid, in_data, result_ready,
      output in_ready, result_valid, result, overflow, beat_count
   );
endinterface

// File: rtl/accumulator_par.sv
// accumulator_par: multi-lane block accumulator.
// Takes LANES unsigned DATA_W samples per beat, reduces them through a
// registered adder tree and sums BLOCK_BEATS beats into one SUM_W result,
// offered on a valid/ready result port before the next block starts.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; also forces in_ready low while high
//   clear  : synchronous abort of the current block, result zeroed
//   bus    : accumulator_par_if.slave (input beats, result, overflow,
//            beat_count)
// Optional build macro ACC_SAT_EN: accumulate add saturates at 2^SUM_W-1
// instead of wrapping. overflow, ports and latency are the same either way.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACCUM | accepting beats, in_ready=1
// ST_DRAIN | last beat taken, waiting for the tree/accumulator to empty
// ST_HOLD  | result_valid=1, waiting for result_ready
module accumulator_par #(
   parameter int DATA_W      = 16,
   parameter int LANES       = 4,
   parameter int SUM_W       = 32,
   parameter int BLOCK_BEATS = 256
) (
   input logic               clk,
   input logic               reset,
   input logic               clear,
   accumulator_par_if.slave  bus
);
   localparam int LEVELS = $clog2(LANES);
   localparam int LAT    = LEVELS + 2;
   localparam int CNT_W  = $clog2(LAT);
   localparam int BC_W   = $clog2(BLOCK_BEATS + 1);
   // Heap-ordered tree: node 0 is the root, leaves are LANES-1 .. 2*LANES-2.
   localparam int NODES  = 2*LANES - 1;

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]       state_q,      state_d;
   logic [BC_W-1:0]  beat_count_q, beat_count_d;
   logic [CNT_W-1:0] drain_cnt_q,  drain_cnt_d;
   logic [LEVELS:0]  vld_q,        vld_d;
   logic [SUM_W-1:0] node_q [NODES];
   logic [SUM_W-1:0] node_d [NODES];
   logic [SUM_W-1:0] acc_q,        acc_d;
   logic             ovf_q,        ovf_d;
   logic [SUM_W-1:0] result_q,     result_d;
   logic [SUM_W:0]   sum_ext;
   logic             in_ready;
   logic             accept;

   assign in_ready = (state_q == ST_ACCUM) && !reset;
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready     = in_ready;
   assign bus.result_valid = (state_q == ST_HOLD);
   assign bus.result       = result_q;
   assign bus.overflow     = ovf_q;
   assign bus.beat_count   = beat_count_q;

   always_comb begin
      state_d      = state_q;
      beat_count_d = beat_count_q;
      drain_cnt_d  = drain_cnt_q;
      node_d       = node_q;
      acc_d        = acc_q;
      ovf_d        = ovf_q;
      result_d     = result_q;
      sum_ext      = {1'b0, acc_q} + {1'b0, node_q[0]};

      // Internal nodes are recomputed every cycle; only valid data is summed.
      for (int i = 0; i < LANES-1; i++) begin
         node_d[i] = node_q[2*i+1] + node_q[2*i+2];
      end
      if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            node_d[LANES-1+i] = SUM_W'(bus.in_data[i*DATA_W +: DATA_W]);
         end
      end

      vld_d[0] = accept;
      for (int i = 1; i <= LEVELS; i++) begin
         vld_d[i] = vld_q[i-1];
      end

      if (vld_q[LEVELS]) begin
`ifdef ACC_SAT_EN
         // Once saturated, further carries keep the value pinned at max.
         acc_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`else
         acc_d = sum_ext[SUM_W-1:0];
`endif
         ovf_d = ovf_q | sum_ext[SUM_W];
      end

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               beat_count_d = beat_count_q + 1'b1;
               if (beat_count_q == BC_W'(BLOCK_BEATS - 1)) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = CNT_W'(LAT - 1);
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == '0) begin
               state_d  = ST_HOLD;
               result_d = acc_q;
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (bus.result_ready) begin
               state_d      = ST_ACCUM;
               acc_d        = '0;
               ovf_d        = 1'b0;
               beat_count_d = '0;
               vld_d        = '0;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      if (clear) begin
         state_d      = ST_ACCUM;
         beat_count_d = '0;
         drain_cnt_d  = '0;
         vld_d        = '0;
         acc_d        = '0;
         ovf_d        = 1'b0;
         result_d     = '0;
         for (int i = 0; i < NODES; i++) begin
            node_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ACCUM;
         beat_count_q <= '0;
         drain_cnt_q  <= '0;
         vld_q        <= '0;
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         result_q     <= '0;
         for (int i = 0; i < NODES; i++) begin
            node_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         beat_count_q <= beat_count_d;
         drain_cnt_q  <= drain_cnt_d;
         vld_q        <= vld_d;
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         result_q     <= result_d;
         node_q       <= node_d;
      end
   end
endmodule

// File: tb/tb_accumulator_par.sv
// tb_accumulator_par: directed bench for accumulator_par.
// Three instances: s (LANES=4, BLOCK_BEATS=4, SUM_W=18) for the handshake,
// latency, overflow, clear and reset cases; m (LANES=1, BLOCK_BEATS=1) for
// the degenerate corner; d (default parameters) for long random blocks
// checked against a running sum.
module tb_accumulator_par;
   logic clk = 1'b0;
   logic reset;
   logic clear;

   always #5 clk = ~clk;

   accumulator_par_if #(.DATA_W(16), .LANES(4), .SUM_W(18), .BLOCK_BEATS(4)) s_if ();
   accumulator_par_if #(.DATA_W(16), .LANES(1), .SUM_W(16), .BLOCK_BEATS(1)) m_if ();
   accumulator_par_if #(.DATA_W(16), .LANES(4), .SUM_W(32), .BLOCK_BEATS(256)) d_if ();

   accumulator_par #(.DATA_W(16), .LANES(4), .SUM_W(18), .BLOCK_BEATS(4)) u_dut_s (
      .clk(clk), .reset(reset), .clear(clear), .bus(s_if));
   accumulator_par #(.DATA_W(16), .LANES(1), .SUM_W(16), .BLOCK_BEATS(1)) u_dut_m (
      .clk(clk), .reset(reset), .clear(clear), .bus(m_if));
   accumulator_par #(.DATA_W(16), .LANES(4), .SUM_W(32), .BLOCK_BEATS(256)) u_dut_d (
      .clk(clk), .reset(reset), .clear(clear), .bus(d_if));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic send_s(input logic [63:0] data);
      int t = 0;
      s_if.in_data  = data;
      s_if.in_valid = 1'b1;
      while (!s_if.in_ready && t < 50) begin tick(); t++; end
      if (t >= 50) chk("s_ready_timeout", 64'(t), 64'd0);
      tick();
      s_if.in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [15:0] data);
      int t = 0;
      m_if.in_data  = data;
      m_if.in_valid = 1'b1;
      while (!m_if.in_ready && t < 50) begin tick(); t++; end
      if (t >= 50) chk("m_ready_timeout", 64'(t), 64'd0);
      tick();
      m_if.in_valid = 1'b0;
   endtask

   task automatic send_d(input logic [63:0] data);
      int t = 0;
      d_if.in_data  = data;
      d_if.in_valid = 1'b1;
      while (!d_if.in_ready && t < 50) begin tick(); t++; end
      if (t >= 50) chk("d_ready_timeout", 64'(t), 64'd0);
      tick();
      d_if.in_valid = 1'b0;
   endtask

   // Edges from the last accepted beat until result_valid is seen.
   task automatic wait_rv_s(output int n);
      n = 0;
      while (!s_if.result_valid && n < 40) begin tick(); n++; end
   endtask

   task automatic block_s(input int base, input int step);
      for (int b = 0; b < 4; b++)
         send_s(pk(base + 4*b*step, base + (4*b+1)*step, base + (4*b+2)*step, base + (4*b+3)*step));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      logic [63:0] data;
      logic [63:0] exp;

      reset = 1'b1;
      clear = 1'b0;
      s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.result_ready = 1'b1;
      m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.result_ready = 1'b1;
      d_if.in_valid = 1'b0; d_if.in_data = '0; d_if.result_ready = 1'b0;
      repeat (3) tick();

      chk("rst_in_ready", 64'(s_if.in_ready), 64'd0);
      chk("rst_result_valid", 64'(s_if.result_valid), 64'd0);
      chk("rst_result", 64'(s_if.result), 64'd0);
      chk("rst_overflow", 64'(s_if.overflow), 64'd0);
      chk("rst_beat_count", 64'(s_if.beat_count), 64'd0);
      reset = 1'b0;
      #1;
      chk("rel_in_ready", 64'(s_if.in_ready), 64'd1);

      // Back-to-back block of 1..16.
      block_s(1, 1);
      wait_rv_s(n);
      chk("b2b_latency", 64'(n), 64'd4);
      chk("b2b_result", 64'(s_if.result), 64'd136);
      chk("b2b_overflow", 64'(s_if.overflow), 64'd0);
      tick();
      chk("b2b_rv_one_cycle", 64'(s_if.result_valid), 64'd0);
      chk("b2b_in_ready_after", 64'(s_if.in_ready), 64'd1);
      chk("b2b_bc_cleared", 64'(s_if.beat_count), 64'd0);
      chk("b2b_result_held", 64'(s_if.result), 64'd136);

      // Same data with three idle cycles before every beat.
      chk("gap_bc0", 64'(s_if.beat_count), 64'd0);
      for (int b = 0; b < 4; b++) begin
         repeat (3) tick();
         send_s(pk(4*b+1, 4*b+2, 4*b+3, 4*b+4));
         chk("gap_bc", 64'(s_if.beat_count), 64'(b + 1));
      end
      wait_rv_s(n);
      chk("gap_latency", 64'(n), 64'd4);
      chk("gap_result", 64'(s_if.result), 64'd136);
      tick();

      // Consumer stalls for 10 cycles while the producer keeps pushing.
      s_if.result_ready = 1'b0;
      block_s(1, 1);
      wait_rv_s(n);
      chk("stall_result", 64'(s_if.result), 64'd136);
      s_if.in_valid = 1'b1;
      s_if.in_data  = pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      bad = 0;
      repeat (10) begin
         tick();
         if (!s_if.result_valid || s_if.in_ready || s_if.result != 18'd136 || s_if.beat_count != 3'd4)
            bad++;
      end
      chk("stall_hold_stable", 64'(bad), 64'd0);
      s_if.in_valid = 1'b0;
      s_if.result_ready = 1'b1;
      tick();
      chk("stall_release_rv", 64'(s_if.result_valid), 64'd0);
      chk("stall_nothing_absorbed", 64'(s_if.beat_count), 64'd0);
      block_s(1, 0);
      wait_rv_s(n);
      chk("after_stall_result", 64'(s_if.result), 64'd16);
      tick();

      // 18-bit accumulator overflow.
      for (int b = 0; b < 4; b++) send_s(pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
      wait_rv_s(n);
      chk("ovf_latency", 64'(n), 64'd4);
`ifdef ACC_SAT_EN
      chk("ovf_result", 64'(s_if.result), 64'd262143);
`else
      chk("ovf_result", 64'(s_if.result), 64'd262128);
`endif
      chk("ovf_flag", 64'(s_if.overflow), 64'd1);
      tick();
      chk("ovf_flag_cleared", 64'(s_if.overflow), 64'd0);
      block_s(1, 0);
      wait_rv_s(n);
      chk("post_ovf_result", 64'(s_if.result), 64'd16);
      chk("post_ovf_flag", 64'(s_if.overflow), 64'd0);
      tick();

      // clear after two beats, with a simultaneous beat that must be dropped.
      send_s(pk(1, 2, 3, 4));
      send_s(pk(5, 6, 7, 8));
      s_if.in_valid = 1'b1;
      s_if.in_data  = pk(9, 9, 9, 9);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      s_if.in_valid = 1'b0;
      chk("clr_beat_count", 64'(s_if.beat_count), 64'd0);
      chk("clr_result", 64'(s_if.result), 64'd0);
      chk("clr_rv", 64'(s_if.result_valid), 64'd0);
      block_s(2, 0);
      wait_rv_s(n);
      chk("clr_next_result", 64'(s_if.result), 64'd32);
      tick();

      // Reset while holding a result.
      s_if.result_ready = 1'b0;
      for (int b = 0; b < 4; b++) send_s(pk(1, 2, 3, 4));
      wait_rv_s(n);
      chk("rsthold_result", 64'(s_if.result), 64'd40);
      reset = 1'b1;
      tick();
      chk("rsthold_rv", 64'(s_if.result_valid), 64'd0);
      chk("rsthold_result0", 64'(s_if.result), 64'd0);
      chk("rsthold_in_ready", 64'(s_if.in_ready), 64'd0);
      reset = 1'b0;
      #1;
      chk("rsthold_in_ready_rel", 64'(s_if.in_ready), 64'd1);
      s_if.result_ready = 1'b1;
      tick();

      // Single lane, single beat per block.
      send_m(16'h1234);
      chk("m_beat_count", 64'(m_if.beat_count), 64'd1);
      chk("m_in_ready_drain", 64'(m_if.in_ready), 64'd0);
      n = 0;
      while (!m_if.result_valid && n < 40) begin tick(); n++; end
      chk("m_latency", 64'(n), 64'd2);
      chk("m_result", 64'(m_if.result), 64'h1234);
      tick();
      send_m(16'hFFFF);
      n = 0;
      while (!m_if.result_valid && n < 40) begin tick(); n++; end
      chk("m_latency2", 64'(n), 64'd2);
      chk("m_result2", 64'(m_if.result), 64'hFFFF);
      chk("m_overflow2", 64'(m_if.overflow), 64'd0);
      tick();

      // Default parameters: three random blocks with producer/consumer stalls.
      for (int blk = 0; blk < 3; blk++) begin
         exp = '0;
         for (int b = 0; b < 256; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            data = {$urandom, $urandom};
            for (int l = 0; l < 4; l++) exp = exp + 64'(data[16*l +: 16]);
            send_d(data);
         end
         n = 0;
         while (!d_if.result_valid && n < 40) begin tick(); n++; end
         chk("rnd_latency", 64'(n), 64'd4);
         repeat ($urandom_range(0, 4)) tick();
         chk("rnd_result", 64'(d_if.result), {32'd0, exp[31:0]});
         chk("rnd_rv_held", 64'(d_if.result_valid), 64'd1);
         d_if.result_ready = 1'b1;
         tick();
         d_if.result_ready = 1'b0;
         chk("rnd_rv_dropped", 64'(d_if.result_valid), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
